// File: rtl/view_trig_sequencer.sv
// Camera basis sequencer: four shared trig lookups, four serial products from one
// multiplier, and an atomic commit of the nine forward/up/right components.
module view_trig_sequencer #(
  parameter int TRIG_TIMEOUT = 255
) (
  input  logic               clk_100mhz,
  input  logic               rst_in,
  input  logic               start,
  input  logic [15:0]        pitch,
  input  logic [15:0]        yaw,
  output logic               trig_req,
  output logic [7:0]         trig_angle,
  output logic               trig_is_cos,
  input  logic               trig_valid,
  input  logic signed [15:0] trig_value,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic signed [15:0] x_forward,
  output logic signed [15:0] y_forward,
  output logic signed [15:0] z_forward,
  output logic signed [15:0] x_up,
  output logic signed [15:0] y_up,
  output logic signed [15:0] z_up,
  output logic signed [15:0] x_right,
  output logic signed [15:0] y_right,
  output logic signed [15:0] z_right
);

  localparam int CW = $clog2(TRIG_TIMEOUT + 1);
  localparam logic [CW:0] TIMEOUT_C = (CW + 1)'(TRIG_TIMEOUT);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, MUL, COMMIT} state_t;

  state_t            state_q, state_d;
  logic [1:0]        k_q, k_d;
  logic [1:0]        m_q, m_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW:0]       cnt_inc;
  logic              timeout_q, timeout_d;
  logic              accept;
  logic [7:0]        pitch_idx_q, yaw_idx_q;
  logic signed [15:0] slot_q [4];
  logic signed [15:0] p0_q, p1_q, p2_q;
  logic signed [15:0] xf_q, yf_q, zf_q, xu_q, yu_q, zu_q, xr_q, zr_q;
  logic signed [31:0] op_a, op_b, product, prod_shift;
  logic signed [15:0] mul_res;
  logic              unused_lsbs;

  // Slots hold sin(pitch), cos(pitch), sin(yaw), cos(yaw) in lookup order.
  wire logic signed [15:0] sp = slot_q[0];
  wire logic signed [15:0] cp = slot_q[1];
  wire logic signed [15:0] sy = slot_q[2];
  wire logic signed [15:0] cy = slot_q[3];

  assign unused_lsbs = ^{pitch[7:0], yaw[7:0]};
  assign cnt_inc     = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};

  // m=0..3 selects cp*sy, cp*cy, sp*sy, sp*cy.
  assign op_a       = m_q[1] ? {{16{sp[15]}}, sp} : {{16{cp[15]}}, cp};
  assign op_b       = m_q[0] ? {{16{cy[15]}}, cy} : {{16{sy[15]}}, sy};
  assign product    = op_a * op_b;
  assign prod_shift = product >>> 14;
  assign mul_res    = prod_shift[15:0];

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    m_d         = m_q;
    cnt_d       = cnt_q;
    timeout_d   = 1'b0;
    accept      = 1'b0;
    trig_req    = 1'b0;
    trig_angle  = 8'd0;
    trig_is_cos = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_q)
      IDLE, COMMIT: begin
        done    = (state_q == COMMIT);
        state_d = IDLE;
        if (start) begin
          accept  = 1'b1;
          k_d     = 2'd0;
          state_d = REQ;
        end
      end
      REQ: begin
        busy        = 1'b1;
        trig_req    = 1'b1;
        trig_angle  = k_q[1] ? yaw_idx_q : pitch_idx_q;
        trig_is_cos = k_q[0];
        cnt_d       = '0;
        state_d     = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (trig_valid) begin
          if (k_q == 2'd3) begin
            m_d     = 2'd0;
            state_d = MUL;
          end else begin
            k_d     = k_q + 2'd1;
            state_d = REQ;
          end
        end else if (cnt_inc == TIMEOUT_C) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_inc[CW-1:0];
        end
      end
      MUL: begin
        busy = 1'b1;
        m_d  = m_q + 2'd1;
        if (m_q == 2'd3) state_d = COMMIT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_100mhz or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      k_q         <= 2'd0;
      m_q         <= 2'd0;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
      pitch_idx_q <= 8'd0;
      yaw_idx_q   <= 8'd0;
      for (int i = 0; i < 4; i++) slot_q[i] <= '0;
      p0_q <= '0; p1_q <= '0; p2_q <= '0;
      xf_q <= '0; yf_q <= '0; zf_q <= '0;
      xu_q <= '0; yu_q <= '0; zu_q <= '0;
      xr_q <= '0; zr_q <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      m_q       <= m_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      if (accept) begin
        pitch_idx_q <= pitch[15:8];
        yaw_idx_q   <= yaw[15:8];
      end
      if (state_q == WAIT && trig_valid) slot_q[k_q] <= trig_value;
      if (state_q == MUL) begin
        case (m_q)
          2'd0: p0_q <= mul_res;
          2'd1: p1_q <= mul_res;
          2'd2: p2_q <= mul_res;
          default: begin
            // Last product feeds the commit directly so outputs land with done.
            xf_q <= p0_q;  yf_q <= -sp;  zf_q <= p1_q;
            xu_q <= p2_q;  yu_q <= cp;   zu_q <= mul_res;
            xr_q <= cy;    zr_q <= -sy;
          end
        endcase
      end
    end
  end

  assign timeout   = timeout_q;
  assign x_forward = xf_q;
  assign y_forward = yf_q;
  assign z_forward = zf_q;
  assign x_up      = xu_q;
  assign y_up      = yu_q;
  assign z_up      = zu_q;
  assign x_right   = xr_q;
  assign y_right   = 16'sd0;
  assign z_right   = zr_q;

endmodule

// File: tb/tb_view_trig_sequencer.sv
// Bench for view_trig_sequencer: behavioural trig responder with configurable
// latency, table vectors, random angles against an arithmetic model, and corner sequences.
module tb_view_trig_sequencer;

  logic               clk_100mhz = 1'b0;
  logic               rst_in;
  logic               start;
  logic [15:0]        pitch, yaw;
  logic               trig_req;
  logic [7:0]         trig_angle;
  logic               trig_is_cos;
  logic               trig_valid = 1'b0;
  logic signed [15:0] trig_value = '0;
  logic               busy, done, timeout;
  logic signed [15:0] x_forward, y_forward, z_forward;
  logic signed [15:0] x_up, y_up, z_up;
  logic signed [15:0] x_right, y_right, z_right;

  view_trig_sequencer #(.TRIG_TIMEOUT(255)) dut (
    .clk_100mhz(clk_100mhz), .rst_in(rst_in), .start(start),
    .pitch(pitch), .yaw(yaw),
    .trig_req(trig_req), .trig_angle(trig_angle), .trig_is_cos(trig_is_cos),
    .trig_valid(trig_valid), .trig_value(trig_value),
    .busy(busy), .done(done), .timeout(timeout),
    .x_forward(x_forward), .y_forward(y_forward), .z_forward(z_forward),
    .x_up(x_up), .y_up(y_up), .z_up(z_up),
    .x_right(x_right), .y_right(y_right), .z_right(z_right)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  int cyc = 0;
  always @(posedge clk_100mhz) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Responder / monitor state (written only by the negedge process below)
  int due_q[$];
  logic signed [15:0] val_q[$];
  int req_cnt = 0, done_cnt = 0, timeout_cnt = 0;
  int done_cyc = 0, timeout_cyc = 0, drop_cyc = 0;
  bit busy_at_to = 1'b0;
  // Controls (written only by the main process)
  int lat = 1;
  int drop_req_no = 0;
  int stray_cyc = -1;

  function automatic logic signed [15:0] trig_ref(input int idx, input bit is_cos);
    real a, v;
    a = 2.0 * 3.14159265358979 * real'(idx) / 256.0;
    v = (is_cos ? $cos(a) : $sin(a)) * 16384.0;
    if (v >= 0.0) return 16'($rtoi(v + 0.5));
    else          return 16'(-$rtoi(-v + 0.5));
  endfunction

  always @(negedge clk_100mhz) begin
    bit hit;
    hit = 1'b0;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      hit = 1'b1;
      void'(due_q.pop_front());
    end
    trig_valid = hit || (cyc == stray_cyc);
    trig_value = hit ? val_q.pop_front() : 16'($urandom);
    if (trig_req) begin
      req_cnt++;
      if (req_cnt == drop_req_no) drop_cyc = cyc;
      else begin
        due_q.push_back(cyc + lat);
        val_q.push_back(trig_ref(int'(trig_angle), trig_is_cos));
      end
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (timeout) begin timeout_cnt++; timeout_cyc = cyc; busy_at_to = busy; end
  end

  // Reference: floor((a*b)/2^14), kept to 16 bits
  function automatic logic signed [15:0] qmul(input int a, input int b);
    longint pr, q;
    pr = longint'(a) * longint'(b);
    q  = pr / 16384;
    if (pr < 0 && (pr % 16384) != 0) q = q - 1;
    return 16'(q);
  endfunction

  logic signed [15:0] exp_o [9];
  string names [9] = '{"x_forward", "y_forward", "z_forward", "x_up", "y_up", "z_up",
                       "x_right", "y_right", "z_right"};

  task automatic compute_exp(input logic [15:0] p, input logic [15:0] y);
    int sp, cp, sy, cy;
    sp = trig_ref(int'(p[15:8]), 1'b0);
    cp = trig_ref(int'(p[15:8]), 1'b1);
    sy = trig_ref(int'(y[15:8]), 1'b0);
    cy = trig_ref(int'(y[15:8]), 1'b1);
    exp_o[0] = qmul(cp, sy); exp_o[1] = 16'(-sp); exp_o[2] = qmul(cp, cy);
    exp_o[3] = qmul(sp, sy); exp_o[4] = 16'(cp);  exp_o[5] = qmul(sp, cy);
    exp_o[6] = 16'(cy);      exp_o[7] = 16'sd0;   exp_o[8] = 16'(-sy);
  endtask

  function automatic logic signed [15:0] out_i(input int i);
    case (i)
      0: return x_forward;
      1: return y_forward;
      2: return z_forward;
      3: return x_up;
      4: return y_up;
      5: return z_up;
      6: return x_right;
      7: return y_right;
      default: return z_right;
    endcase
  endfunction

  task automatic check(input string name, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int i = 0; i < 9; i++)
      check($sformatf("%s_%s", tag, names[i]), longint'(out_i(i)), longint'(exp_o[i]));
  endtask

  task automatic tick();
    @(negedge clk_100mhz);
    #1;
  endtask

  task automatic wait_done(input int d0, input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (done_cnt != d0) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s_done_wait: got no done pulse, expected one within 2000 cycles", tag);
    end
  endtask

  // Start one computation; returns cycles from start sample to done.
  task automatic run_op(input logic [15:0] p, input logic [15:0] y, input int l,
                        input string tag, output int dl, output bit ok);
    int s, d0;
    lat = l; pitch = p; yaw = y; start = 1'b1;
    s = cyc; d0 = done_cnt;
    tick();
    start = 1'b0;
    wait_done(d0, tag, ok);
    dl = done_cyc - s;
    $display("op %s: pitch=%h yaw=%h L=%0d done_after=%0d fwd=(%0d,%0d,%0d) up=(%0d,%0d,%0d) right=(%0d,%0d,%0d)",
             tag, p, y, l, dl, x_forward, y_forward, z_forward, x_up, y_up, z_up,
             x_right, y_right, z_right);
  endtask

  typedef struct packed {
    logic [15:0]       pitch;
    logic [15:0]       yaw;
    logic [7:0]        lat;
    logic [8:0][15:0]  expv;
  } vec_t;
  vec_t tbl [3];

  task automatic set_vec(input int n, input logic [15:0] p, input logic [15:0] y, input int l,
                         input int fx, input int fy, input int fz, input int ux, input int uy,
                         input int uz, input int rx, input int ry, input int rz);
    tbl[n].pitch = p; tbl[n].yaw = y; tbl[n].lat = 8'(l);
    tbl[n].expv[0] = 16'(fx); tbl[n].expv[1] = 16'(fy); tbl[n].expv[2] = 16'(fz);
    tbl[n].expv[3] = 16'(ux); tbl[n].expv[4] = 16'(uy); tbl[n].expv[5] = 16'(uz);
    tbl[n].expv[6] = 16'(rx); tbl[n].expv[7] = 16'(ry); tbl[n].expv[8] = 16'(rz);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dl, s, d0, d1, r0, t0;
    bit ok, seen_busy;
    logic [15:0] pa, ya;

    rst_in = 1'b1; start = 1'b0; pitch = '0; yaw = '0;
    set_vec(0, 16'h0000, 16'h0000, 1, 0, 0, 16384, 0, 16384, 0, 16384, 0, 0);
    set_vec(1, 16'h4000, 16'h0000, 3, 0, -16384, 0, 0, 0, 16384, 16384, 0, 0);
    set_vec(2, 16'h0000, 16'hC000, 2, -16384, 0, 0, 0, 16384, 0, 0, 0, 16384);

    repeat (3) tick();
    for (int i = 0; i < 9; i++) exp_o[i] = '0;
    check_outputs("reset");
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_timeout", timeout, 0);
    check("reset_trig_req", trig_req, 0);
    rst_in = 1'b0;
    tick();

    // Directed vectors
    for (int n = 0; n < 3; n++) begin
      run_op(tbl[n].pitch, tbl[n].yaw, int'(tbl[n].lat), $sformatf("vec%0d", n), dl, ok);
      if (ok) begin
        check($sformatf("vec%0d_latency", n), dl, 4 * int'(tbl[n].lat) + 9);
        for (int i = 0; i < 9; i++) exp_o[i] = $signed(tbl[n].expv[i]);
        check_outputs($sformatf("vec%0d", n));
      end
    end

    // Random angles and latencies against the arithmetic model
    for (int n = 0; n < 16; n++) begin
      pa = 16'($urandom); ya = 16'($urandom);
      s = int'($urandom_range(1, 4));
      run_op(pa, ya, s, $sformatf("rnd%0d", n), dl, ok);
      if (ok) begin
        check($sformatf("rnd%0d_latency", n), dl, 4 * s + 9);
        compute_exp(pa, ya);
        check_outputs($sformatf("rnd%0d", n));
      end
    end

    // Second lookup never answered: exactly one timeout, outputs retained
    drop_req_no = req_cnt + 2; t0 = timeout_cnt; d0 = done_cnt;
    lat = 1; pitch = 16'h1234; yaw = 16'h5678; start = 1'b1;
    tick();
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (timeout_cnt != t0) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL to_wait: got no timeout pulse, expected one within 600 cycles");
    end else begin
      check("to_delay", timeout_cyc - drop_cyc, 256);
      check("to_busy", busy_at_to, 0);
    end
    repeat (3) tick();
    check("to_count", timeout_cnt - t0, 1);
    check("to_no_done", done_cnt - d0, 0);
    check_outputs("to_retain");
    $display("timeout seq: timeouts=%0d delay=%0d", timeout_cnt - t0, timeout_cyc - drop_cyc);
    run_op(16'h6000, 16'hA800, 2, "after_to", dl, ok);
    if (ok) begin
      compute_exp(16'h6000, 16'hA800);
      check_outputs("after_to");
    end

    // Stray trig_valid in IDLE, start while busy, start in the done cycle
    stray_cyc = cyc + 1;
    tick(); tick();
    r0 = req_cnt; d0 = done_cnt;
    check("stray_busy", busy, 0);
    lat = 2; pitch = 16'h2A00; yaw = 16'h9100; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    pitch = 16'h7700; yaw = 16'h1300; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(d0, "busy_start", ok);
    if (ok) begin
      compute_exp(16'h2A00, 16'h9100);
      check_outputs("busy_start");
      check("busy_start_reqs", req_cnt - r0, 4);
      check("busy_start_dones", done_cnt - d0, 1);
      $display("busy-start seq: reqs=%0d dones=%0d", req_cnt - r0, done_cnt - d0);
      pitch = 16'hE500; yaw = 16'h5B00; start = 1'b1;
      s = cyc; d1 = done_cnt;
      tick();
      start = 1'b0;
      wait_done(d1, "done_cycle_start", ok);
      if (ok) begin
        check("done_cycle_start_latency", done_cyc - s, 4 * 2 + 9);
        compute_exp(16'hE500, 16'h5B00);
        check_outputs("done_cycle_start");
        repeat (3) tick();
        check("done_cycle_start_dones", done_cnt - d1, 1);
      end
    end

    // Reset during WAIT of lookup 2, then a late trig_valid arrives
    lat = 5; r0 = req_cnt; pitch = 16'h3300; yaw = 16'h4400; start = 1'b1;
    tick();
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (req_cnt == r0 + 3) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL rst_wait: got %0d requests, expected 3", req_cnt - r0);
    end
    tick();
    rst_in = 1'b1;
    #1;
    for (int i = 0; i < 9; i++) exp_o[i] = '0;
    check_outputs("midrst");
    check("midrst_busy", busy, 0);
    tick();
    rst_in = 1'b0;
    d0 = done_cnt; seen_busy = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (busy || trig_req) seen_busy = 1'b1;
    end
    check("midrst_late_valid_busy", seen_busy, 0);
    check("midrst_late_valid_reqs", req_cnt - r0, 3);
    check("midrst_late_valid_dones", done_cnt - d0, 0);
    check_outputs("midrst_hold");
    $display("reset seq: reqs=%0d busy_seen=%0d", req_cnt - r0, seen_busy);
    run_op(16'h0B00, 16'hF100, 1, "after_rst", dl, ok);
    if (ok) begin
      check("after_rst_latency", dl, 13);
      compute_exp(16'h0B00, 16'hF100);
      check_outputs("after_rst");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
